// File: rtl/spram_arb_pkg.sv
// Shared definitions for the two-master SPRAM arbiter: FSM states,
// owner encodings and default parameter widths.
package spram_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } arb_state_t;

    localparam logic OWN_M0 = 1'b0;
    localparam logic OWN_M1 = 1'b1;

    localparam int DEF_ADDR_W = 22;
    localparam int DEF_CNT_W  = 16;

endpackage : spram_arb_pkg

// File: rtl/spram_arbiter_rr_pick2.sv
// Combinational 2-way round-robin picker: a lone requester always wins,
// on a tie the master that did not win last time is chosen.
module rr_pick2
    import spram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic       valid,
    output logic       winner
);

    // Winner selection from the current requests and the previous grant
    always_comb begin
        valid  = |req;
        winner = OWN_M0;
        if (req == 2'b11) begin
            winner = ~last;
        end else if (req[1]) begin
            winner = OWN_M1;
        end
    end

endmodule : rr_pick2

// File: rtl/spram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port SPRAM.
// One access in flight at a time: IDLE -> ACCESS -> ACK -> IDLE.
// Optional build macro SPRAM_ARB_STATS_EN adds saturating grant and
// conflict counters (stat_m0, stat_m1, stat_conflict).
module spram_arbiter
    import spram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  logic        ck,
    input  logic        rst_n,
    input  logic        m0_cyc,
    input  logic        m0_we,
    input  logic [3:0]  m0_sel,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_cyc,
    input  logic        m1_we,
    input  logic [3:0]  m1_sel,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        ram_cyc,
    output logic        ram_we,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
`ifdef SPRAM_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_m0,
    output logic [CNT_W-1:0] stat_m1,
    output logic [CNT_W-1:0] stat_conflict
`endif
);

    localparam logic [31:0] ADDR_MASK =
        (ADDR_W >= 32) ? '1 : ((32'd1 << ADDR_W) - 32'd1);

    arb_state_t  r_state;
    logic        r_owner;
    logic        r_last;
    logic        r_ram_cyc;
    logic [1:0]  r_ack;

    logic [1:0]  w_req;
    logic        w_valid;
    logic        w_winner;
    logic        w_own_we;
    logic [3:0]  w_own_sel;
    logic [31:0] w_own_addr;
    logic [31:0] w_own_wdata;

    assign w_req = {m1_cyc, m0_cyc};

    rr_pick2 u_pick (
        .req    (w_req),
        .last   (r_last),
        .valid  (w_valid),
        .winner (w_winner)
    );

    // Arbitration FSM; ram_cyc and the ack pulses are registered here
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_owner   <= OWN_M0;
            r_last    <= OWN_M1;
            r_ram_cyc <= 1'b0;
            r_ack     <= '0;
        end else begin
            r_ack <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_valid) begin
                        r_owner   <= w_winner;
                        r_last    <= w_winner;
                        r_ram_cyc <= 1'b1;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    r_ack[r_owner] <= 1'b1;
                    r_state        <= ST_ACK;
                end
                ST_ACK: begin
                    r_ram_cyc <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_ram_cyc <= 1'b0;
                    r_state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Forward the owner's request to the RAM and return read data to it
    always_comb begin
        w_own_we    = (r_owner == OWN_M1) ? m1_we    : m0_we;
        w_own_sel   = (r_owner == OWN_M1) ? m1_sel   : m0_sel;
        w_own_addr  = (r_owner == OWN_M1) ? m1_addr  : m0_addr;
        w_own_wdata = (r_owner == OWN_M1) ? m1_wdata : m0_wdata;

        ram_cyc   = r_ram_cyc;
        ram_we    = (r_state == ST_ACCESS) ? w_own_we : 1'b0;
        ram_sel   = r_ram_cyc ? w_own_sel : '0;
        ram_addr  = r_ram_cyc ? (w_own_addr & ADDR_MASK) : '0;
        ram_wdata = r_ram_cyc ? w_own_wdata : '0;

        m0_ack   = r_ack[0];
        m1_ack   = r_ack[1];
        m0_rdata = r_ack[0] ? ram_rdata : '0;
        m1_rdata = r_ack[1] ? ram_rdata : '0;
    end

`ifdef SPRAM_ARB_STATS_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_stat_m0;
    logic [CNT_W-1:0] r_stat_m1;
    logic [CNT_W-1:0] r_stat_conflict;

    // Saturating grant and contention counters, evaluated in IDLE only
    always_ff @(posedge ck) begin
        if (!rst_n) begin
            r_stat_m0       <= '0;
            r_stat_m1       <= '0;
            r_stat_conflict <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_valid && (w_winner == OWN_M0) && (r_stat_m0 != '1))
                r_stat_m0 <= r_stat_m0 + CNT_ONE;
            if (w_valid && (w_winner == OWN_M1) && (r_stat_m1 != '1))
                r_stat_m1 <= r_stat_m1 + CNT_ONE;
            if ((&w_req) && (r_stat_conflict != '1))
                r_stat_conflict <= r_stat_conflict + CNT_ONE;
        end
    end

    assign stat_m0       = r_stat_m0;
    assign stat_m1       = r_stat_m1;
    assign stat_conflict = r_stat_conflict;
`else
    localparam int W_UNUSED_CNT_W = CNT_W;
`endif

endmodule : spram_arbiter

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural SPRAM (byte-lane
// writes, 1-cycle registered read). Define SPRAM_ARB_STATS_EN for both
// bench and RTL to exercise the statistics counters.
module tb_spram_arbiter;

    logic        ck = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_cyc = 1'b0, m0_we = 1'b0;
    logic [3:0]  m0_sel = '0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic [31:0] m0_rdata;
    logic        m0_ack;
    logic        m1_cyc = 1'b0, m1_we = 1'b0;
    logic [3:0]  m1_sel = '0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic [31:0] m1_rdata;
    logic        m1_ack;
    logic        ram_cyc, ram_we;
    logic [3:0]  ram_sel;
    logic [31:0] ram_addr, ram_wdata;
    logic [31:0] ram_rdata = '0;
`ifdef SPRAM_ARB_STATS_EN
    logic [15:0] stat_m0, stat_m1, stat_conflict;
`endif

    int total = 0;
    int bad   = 0;

    always #5 ck = ~ck;

    spram_arbiter #(.ADDR_W(22), .CNT_W(16)) dut (
        .ck        (ck),
        .rst_n     (rst_n),
        .m0_cyc    (m0_cyc),
        .m0_we     (m0_we),
        .m0_sel    (m0_sel),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_rdata  (m0_rdata),
        .m0_ack    (m0_ack),
        .m1_cyc    (m1_cyc),
        .m1_we     (m1_we),
        .m1_sel    (m1_sel),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_rdata  (m1_rdata),
        .m1_ack    (m1_ack),
        .ram_cyc   (ram_cyc),
        .ram_we    (ram_we),
        .ram_sel   (ram_sel),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata)
`ifdef SPRAM_ARB_STATS_EN
        ,
        .stat_m0       (stat_m0),
        .stat_m1       (stat_m1),
        .stat_conflict (stat_conflict)
`endif
    );

    // Behavioural SPRAM: 32K words, read-first, registered read data
    logic [31:0] mem [0:32767];
    initial for (int i = 0; i < 32768; i++) mem[i] = '0;
    always @(posedge ck) begin
        if (ram_cyc) begin
            if (ram_we)
                for (int b = 0; b < 4; b++)
                    if (ram_sel[b]) mem[ram_addr[16:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr[16:2]];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ck);
        #1;
    endtask

    // Complete one access from IDLE; checks ack latency and returns rdata
    task automatic do_access(input bit m, input logic we, input logic [3:0] sel,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rd);
        int  n;
        bit  got;
        rd = '0;
        if (m) begin
            m1_we = we; m1_sel = sel; m1_addr = addr; m1_wdata = wdata; m1_cyc = 1'b1;
        end else begin
            m0_we = we; m0_sel = sel; m0_addr = addr; m0_wdata = wdata; m0_cyc = 1'b1;
        end
        n = 0;
        got = 1'b0;
        while (!got && n < 8) begin
            tick();
            n++;
            if (m ? m1_ack : m0_ack) begin
                got = 1'b1;
                rd  = m ? m1_rdata : m0_rdata;
            end
        end
        check_eq("acc_latency", n, 2);
        m0_cyc = 1'b0;
        m1_cyc = 1'b0;
        tick();
    endtask

    logic [31:0] rd;
    logic        e0, e1;

    initial begin
        // Reset state
        repeat (3) tick();
        check_eq("rst_ram_cyc", ram_cyc, 0);
        check_eq("rst_ram_we", ram_we, 0);
        check_eq("rst_ram_sel", ram_sel, 0);
        check_eq("rst_ram_addr", ram_addr, 0);
        check_eq("rst_ram_wdata", ram_wdata, 0);
        check_eq("rst_m0_ack", m0_ack, 0);
        check_eq("rst_m1_ack", m1_ack, 0);
        check_eq("rst_m0_rdata", m0_rdata, 0);
        check_eq("rst_m1_rdata", m1_rdata, 0);
`ifdef SPRAM_ARB_STATS_EN
        check_eq("rst_stat_m0", stat_m0, 0);
        check_eq("rst_stat_m1", stat_m1, 0);
        check_eq("rst_stat_conf", stat_conflict, 0);
`endif
        rst_n = 1'b1;
        tick();

        // m0 full-word write to 0x100
        m0_we = 1'b1; m0_sel = 4'b1111; m0_addr = 32'h100; m0_wdata = 32'hDEADBEEF; m0_cyc = 1'b1;
        tick();
        check_eq("w_acc_cyc", ram_cyc, 1);
        check_eq("w_acc_we", ram_we, 1);
        check_eq("w_acc_sel", ram_sel, 4'hF);
        check_eq("w_acc_addr", ram_addr, 32'h100);
        check_eq("w_acc_wdata", ram_wdata, 32'hDEADBEEF);
        check_eq("w_acc_m0_ack", m0_ack, 0);
        tick();
        check_eq("w_ack_m0_ack", m0_ack, 1);
        check_eq("w_ack_m1_ack", m1_ack, 0);
        check_eq("w_ack_cyc", ram_cyc, 1);
        check_eq("w_ack_we", ram_we, 0);
        m0_cyc = 1'b0;
        tick();
        check_eq("w_idle_cyc", ram_cyc, 0);
        check_eq("w_idle_sel", ram_sel, 0);
        check_eq("w_idle_m0_ack", m0_ack, 0);

        // m1 reads it back
        m1_we = 1'b0; m1_sel = 4'b1111; m1_addr = 32'h100; m1_cyc = 1'b1;
        tick();
        check_eq("r_acc_we", ram_we, 0);
        check_eq("r_acc_m1_ack", m1_ack, 0);
        check_eq("r_acc_m1_rdata", m1_rdata, 0);
        tick();
        check_eq("r_ack_m1_ack", m1_ack, 1);
        check_eq("r_ack_m1_rdata", m1_rdata, 32'hDEADBEEF);
        check_eq("r_ack_m0_ack", m0_ack, 0);
        check_eq("r_ack_m0_rdata", m0_rdata, 0);
        check_eq("r_ack_we", ram_we, 0);
        m1_cyc = 1'b0;
        tick();

        // Byte-lane write: 0x11223344 then lane 1 <- 0xAB
        do_access(1'b0, 1'b1, 4'b1111, 32'h200, 32'h11223344, rd);
        do_access(1'b0, 1'b1, 4'b0010, 32'h200, 32'h0000AB00, rd);
        do_access(1'b1, 1'b0, 4'b1111, 32'h200, 32'h0, rd);
        check_eq("lane_rd", rd, 32'h1122AB44);

        // Reset during ACCESS
        m1_we = 1'b1; m1_sel = 4'b1111; m1_addr = 32'h300; m1_wdata = 32'h55AA55AA; m1_cyc = 1'b1;
        tick();
        check_eq("mr_acc_cyc", ram_cyc, 1);
        rst_n = 1'b0;
        tick();
        check_eq("mr_cyc", ram_cyc, 0);
        check_eq("mr_m0_ack", m0_ack, 0);
        check_eq("mr_m1_ack", m1_ack, 0);
        m1_we = 1'b0;
        m0_we = 1'b0; m0_sel = 4'b1111; m0_addr = 32'h100; m0_cyc = 1'b1;
        rst_n = 1'b1;
        tick();
        check_eq("mr_tie_addr", ram_addr, 32'h100);
        check_eq("mr_tie_m1_ack", m1_ack, 0);
        tick();
        check_eq("mr_tie_m0_ack", m0_ack, 1);
        check_eq("mr_tie_m1_ack2", m1_ack, 0);
        check_eq("mr_tie_rdata", m0_rdata, 32'hDEADBEEF);
        m0_cyc = 1'b0; m1_cyc = 1'b0;
        tick();

        // Contention from reset: strict alternation, then two solo m0 grants
        rst_n = 1'b0;
        tick();
        m0_we = 1'b0; m0_sel = 4'b1111; m0_addr = 32'h00000040; m0_cyc = 1'b1;
        m1_we = 1'b0; m1_sel = 4'b1111; m1_addr = 32'hFFC00100; m1_cyc = 1'b1;
        rst_n = 1'b1;
        for (int i = 1; i <= 21; i++) begin
            tick();
            e0 = (i == 2) || (i == 8) || (i == 14) || (i == 17) || (i == 20);
            e1 = (i == 5) || (i == 11);
            check_eq($sformatf("rr_m0_ack_c%0d", i), m0_ack, e0);
            check_eq($sformatf("rr_m1_ack_c%0d", i), m1_ack, e1);
            if (i == 1) check_eq("rr_m0_addr", ram_addr, 32'h40);
            if (i == 4) check_eq("rr_m1_addr_mask", ram_addr, 32'h100);
            if (i == 14) m1_cyc = 1'b0;
            if (i == 20) m0_cyc = 1'b0;
        end
        check_eq("rr_idle_cyc", ram_cyc, 0);
`ifdef SPRAM_ARB_STATS_EN
        check_eq("stat_m0", stat_m0, 5);
        check_eq("stat_m1", stat_m1, 2);
        check_eq("stat_conflict", stat_conflict, 5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spram_arbiter

// File: doc/spram_arbiter.md
Name: spram_arbiter

Overview:
- Two-master arbiter sharing one single-port SPRAM instance (128 kB, 32-bit words, byte-lane writes, 1-cycle registered read).
- Masters use the SoC's cyc/we/sel/addr/wdata/rdata bus plus a one-cycle ack pulse. Typical masters are the CPU data bus and a DMA/peripheral master.
- Sits between the bus masters and the sp_ram wrapper. Round-robin fairness; one access in flight at a time.

Parameters:
- ADDR_W, 22, number of address bits forwarded to RAM; upper bits are forced to 0.
- CNT_W, 16, width of statistics counters (used only with the optional feature).

Ports:
- ck  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- m0_cyc, m1_cyc  in  1  request; held until ack
- m0_we, m1_we  in  1  write enable
- m0_sel, m1_sel  in  4  byte-lane select
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_rdata, m1_rdata  out  32  read data; valid with ack
- m0_ack, m1_ack  out  1  one-cycle completion pulse
- ram_cyc  out  1  to sp_ram cyc
- ram_we  out  1  to sp_ram we
- ram_sel  out  4  to sp_ram sel
- ram_addr  out  32  to sp_ram addr
- ram_wdata  out  32  to sp_ram wdata
- ram_rdata  in  32  from sp_ram rdata
- stat_m0, stat_m1, stat_conflict  out  CNT_W  (only with SPRAM_ARB_STATS_EN)

Behaviour:
- Clock and reset: one clock, ck. Reset rst_n is synchronous and active-low.
- Reset values: state=IDLE, owner=0, last=1 (m0 wins first tie), all ack=0, rdata=0, ram_cyc/ram_we=0, ram_sel=0, ram_addr=0, ram_wdata=0, counters=0.
- State machine: IDLE -> ACCESS -> ACK -> IDLE.
- IDLE:
  - If any cyc is high, pick a winner: the only requester, or on a tie the one != last.
  - Register owner<=winner and last<=winner, then go to ACCESS.
  - Otherwise stay in IDLE.
- ACCESS:
  - ram_cyc=1.
  - ram_we, ram_sel, ram_addr (bits ADDR_W-1:0, rest 0) and ram_wdata come combinationally from the owner's inputs.
  - Write commits this cycle. Go to ACK.
- ACK:
  - ram_cyc=1 and ram_we=0, so the read port stays enabled with no second write.
  - owner's ack=1 and owner's rdata=ram_rdata (also for writes).
  - Go to IDLE.
- Latency and throughput:
  - ack is asserted 2 cycles after cyc is sampled in IDLE.
  - Minimum 3 cycles per access.
  - Back-to-back requests from the two masters alternate strictly.
- Non-owner outputs: ack=0 and rdata=0 at all times. Owner rdata=0 outside ACK.
- Outside ACCESS/ACK: ram_cyc=0, ram_we=0, ram_sel=0.
- Bus rules:
  - A master must hold cyc and its fields stable until ack. Inputs are sampled only during ACCESS.
  - A master that drops cyc during ACCESS still completes; its ack is issued and ignored.
  - cyc still high in the cycle after ack is treated as a new request.
- Reset mid-operation: returns to IDLE next edge; any pending ack is lost. A write in ACCESS that coincides with reset may or may not commit.

Optional Feature:
- Macro: SPRAM_ARB_STATS_EN.
- With the macro:
  - stat_m0 / stat_m1 increment on each grant to m0 / m1.
  - stat_conflict increments when both cyc are high in IDLE.
  - All counters saturate at all-ones and clear on reset.
- Without the macro: stat_* ports and counters are absent.

Decomposition:
- Package spram_arb_pkg:
  - state encoding constants ST_IDLE=2'd0, ST_ACCESS=2'd1, ST_ACK=2'd2.
  - owner constants OWN_M0=1'b0, OWN_M1=1'b1.
  - default widths.
- One natural sub-module, rr_pick2: combinational 2-way round-robin picker. Inputs req[1:0] and last; outputs valid and winner.

Test Plan:
- Reset, then m0 writes addr 0x100, sel 4'b1111, data 0xDEADBEEF -> ram_cyc/ram_we high one cycle later; m0_ack 2 cycles after request; m1_ack stays 0.
- m1 reads 0x100 -> m1_ack pulse with m1_rdata=0xDEADBEEF; ram_we=0 in both ACCESS and ACK.
- Both cyc high from reset -> grant order m0, m1, m0, m1 over 12 cycles; each ack exactly every 3 cycles.
- m0 writes sel=4'b0010, data 0x0000AB00, over 0x11223344 at 0x200; read back -> 0x1122AB44.
- rst_n low during ACCESS -> next cycle ram_cyc=0, all ack=0, state IDLE; after release, m0 wins a tie.
- With SPRAM_ARB_STATS_EN, 5 contended plus 2 solo m0 accesses -> stat_m0=5, stat_m1=2, stat_conflict=4 or 5 per the tie pattern, checked against a model.
